param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/counter_pkg.sv | 8 +
 rtl/param_updown_counter_tff.sv | 22 ++
 rtl/param_updown_counter.sv | 94 +++++++++
 tb/tb_param_updown_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: selects between wrap-around
// and saturating behaviour at the count limits.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : counter_pkg

// File: rtl/param_updown_counter_tff.sv
// Single toggle flip-flop used as one bit of the counter register.
// Toggles on a rising clk edge when t_i is high; clears asynchronously.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else if (t_i) begin
      q_q <= ~q_q;
    end
  end

  assign q_o = q_q;

endmodule : tff_cell

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with clear, load, terminal-count flag and
// wrap/saturate handling; the count register is built from T flip-flops.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        // >= so an out-of-range value is treated as the terminal value
        if (count_q >= MAX_VAL) begin
          if (SATURATE == MODE_SAT) begin
            count_d = MAX_VAL;
            sat_d   = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          if (SATURATE == MODE_SAT) begin
            sat_d = 1'b1;
          end else begin
            count_d = MAX_VAL;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  assign toggle = count_q ^ count_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_tff (
      .clk (clk),
      .rst (rst),
      .t_i (toggle[i]),
      .q_o (count_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;
  assign tc    = up_dn ? (count_q == MAX_VAL) : (count_q == '0);

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: three counter instances (4-bit wrap, 4-bit saturate,
// 8-bit default) share controls and are compared with an arithmetic model.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val4 = '0;
  logic [7:0] load_val8 = '0;
  logic [3:0] cnt0, cnt1;
  logic [7:0] cnt2;
  logic       tc0, tc1, tc2, wrap0, wrap1, wrap2, sat0, sat1, sat2;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt[3]  = '{0, 0, 0};
  int m_wrap[3] = '{0, 0, 0};
  int m_sat[3]  = '{0, 0, 0};
  int m_max[3]  = '{9, 9, 255};
  int m_smode[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val4), .count(cnt0), .tc(tc0), .wrap(wrap0), .sat(sat0));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val4), .count(cnt1), .tc(tc1), .wrap(wrap1), .sat(sat1));

  param_updown_counter u_def (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val8), .count(cnt2), .tc(tc2), .wrap(wrap2), .sat(sat2));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_tc(input int i);
    return up_dn ? int'(m_cnt[i] == m_max[i]) : int'(m_cnt[i] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
    end
  endtask

  // Next state from the counter rules, applied to each instance's model.
  task automatic model_step();
    int lv;
    for (int i = 0; i < 3; i++) begin
      lv = (i == 2) ? int'(load_val8) : int'(load_val4);
      m_wrap[i] = 0;
      m_sat[i]  = 0;
      if (clr) m_cnt[i] = 0;
      else if (load) m_cnt[i] = (lv > m_max[i]) ? m_max[i] : lv;
      else if (en && up_dn) begin
        if (m_cnt[i] < m_max[i]) m_cnt[i]++;
        else if (m_smode[i] == 1) m_sat[i] = 1;
        else begin m_cnt[i] = 0; m_wrap[i] = 1; end
      end else if (en) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        else if (m_smode[i] == 1) m_sat[i] = 1;
        else begin m_cnt[i] = m_max[i]; m_wrap[i] = 1; end
      end
    end
  endtask

  task automatic check_all();
    check("cnt_wrap", int'(cnt0), m_cnt[0]);
    check("cnt_sat",  int'(cnt1), m_cnt[1]);
    check("cnt_def",  int'(cnt2), m_cnt[2]);
    check("wrap_wrap", int'(wrap0), m_wrap[0]);
    check("wrap_sat",  int'(wrap1), m_wrap[1]);
    check("wrap_def",  int'(wrap2), m_wrap[2]);
    check("sat_wrap", int'(sat0), m_sat[0]);
    check("sat_sat",  int'(sat1), m_sat[1]);
    check("sat_def",  int'(sat2), m_sat[2]);
    check("tc_wrap", int'(tc0), m_tc(0));
    check("tc_sat",  int'(tc1), m_tc(1));
    check("tc_def",  int'(tc2), m_tc(2));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic e, input logic u, input logic c,
                       input logic l, input int lv);
    en = e; up_dn = u; clr = c; load = l;
    load_val4 = 4'(lv);
    load_val8 = 8'(lv);
  endtask

  typedef struct {
    logic e, u, c, l;
    int   lv;
    int   exp_cnt, exp_wrap, exp_tc;
  } vec_t;

  vec_t tbl[$];
  int   wrap_pulses;

  initial begin
    for (int i = 1; i <= 12; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0, i % 10, int'(i == 10), int'(i % 10 == 9)});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3,  3, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  2, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  1, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  9, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0,  8, 0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 15, 9, 0, 1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5,  0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4,  4, 0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0,  4, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 0,  0, 0, 1});

    // Asynchronous reset is visible before any clock edge.
    #1;
    check("rst_cnt_wrap", int'(cnt0), 0);
    check("rst_cnt_def", int'(cnt2), 0);
    check("rst_wrap", int'(wrap0), 0);
    check("rst_sat", int'(sat1), 0);
    #1 rst = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].e, tbl[k].u, tbl[k].c, tbl[k].l, tbl[k].lv);
      tick();
      check($sformatf("tbl%0d_cnt", k), int'(cnt0), tbl[k].exp_cnt);
      check($sformatf("tbl%0d_wrap", k), int'(wrap0), tbl[k].exp_wrap);
      check($sformatf("tbl%0d_tc", k), int'(tc0), tbl[k].exp_tc);
      check($sformatf("tbl%0d_sat", k), int'(sat0), 0);
    end

    // Saturating instance held at the upper limit, then released downward.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8);
    tick();
    check("satseq_load", int'(cnt1), 8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
      check($sformatf("satseq_cnt%0d", i), int'(cnt1), 9);
      check($sformatf("satseq_sat%0d", i), int'(sat1), (i == 0) ? 0 : 1);
      check($sformatf("satseq_wrap%0d", i), int'(wrap1), 0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check("satseq_down_cnt", int'(cnt1), 8);
    check("satseq_down_sat", int'(sat1), 0);

    // Reset dropped mid-cycle at count 5, then released.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
      tick();
    end
    check("midrst_pre", int'(cnt0), 5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("midrst_cnt_wrap", int'(cnt0), 0);
    check("midrst_cnt_sat", int'(cnt1), 0);
    check("midrst_cnt_def", int'(cnt2), 0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_first", int'(cnt0), 1);

    // Full 8-bit cycle returns to zero with a single wrap pulse.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    tick();
    wrap_pulses = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 256; i++) begin
      tick();
      wrap_pulses += int'(wrap2);
    end
    check("w8_cnt", int'(cnt2), 0);
    check("w8_pulses", wrap_pulses, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 11) == 0),
            int'($urandom_range(0, 255)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_param_updown_counter
